rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Write side of the register file: the other end of the RF read port used by decode.
- Accepts completed results from the execute stage over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the RF single write port. Exposes a forwarding lookup so decode can see pending writes not yet committed.
- Sits between ID_EXE/execute and RF in the CORE pipeline.

Parameters:
- RFW, 5, register address width (32 registers).
- DW, 32, data width.
- DEPTH, 2, queue entries; power of two, minimum 2.
- CNTW, 16, width of the retired-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- start  input  1  synchronous, active-high reset.
- in_valid  input  1  execute result present.
- in_ready  output  1  block can accept a result this cycle.
- in_we  input  1  instruction writes a destination register.
- in_rd  input  RFW  destination register address.
- in_data  input  DW  result value.
- rf_we  output  1  write request to RF.
- rf_waddr  output  RFW  RF write address.
- rf_wdata  output  DW  RF write data.
- rf_ready  input  1  RF commits the write at this edge.
- fwd_addrA  input  RFW  decode source A address.
- fwd_addrB  input  RFW  decode source B address.
- fwd_hitA  output  1  pending write to fwd_addrA exists.
- fwd_hitB  output  1  pending write to fwd_addrB exists.
- fwd_dataA  output  DW  youngest pending value for A; 0 when no hit.
- fwd_dataB  output  DW  youngest pending value for B; 0 when no hit.
- pending  output  clog2(DEPTH)+1  current queue occupancy.
- retired  output  CNTW  count of completed results.

Behaviour:
- Reset (start=1 at posedge):
  - Clears count, read pointer, write pointer, all entry valid bits, and retired.
  - Reset has priority over push and pop in the same cycle.
  - Queued entries are discarded; none reach RF.
- After reset: rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=1, fwd_hit*=0, fwd_data*=0, pending=0, retired=0.
- in_ready = (count < DEPTH). It is combinational from state only and never depends on in_valid or rf_ready.
- Accept: in_valid && in_ready at the posedge.
  - If in_we=1 and in_rd!=0, the entry {in_rd, in_data} is pushed at the write pointer.
  - If in_we=0 or in_rd==0, nothing is pushed; retired increments at that edge.
- Drain:
  - rf_we = (count != 0).
  - rf_waddr and rf_wdata show the head entry and are combinational from storage. When empty, both are 0.
  - Pop occurs when rf_we && rf_ready. retired increments on each pop.
- Latency: a result accepted at edge N drives rf_we in the cycle after edge N, and commits at the first later edge with rf_ready=1. Minimum is 1 cycle accept-to-commit. There is no input-to-output combinational path.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged; both pointers advance.
- Full (count==DEPTH): in_ready=0, so no push. A pop in that cycle frees a slot, and in_ready rises in the next cycle only.
- Discarded accept and pop in the same cycle: retired += 2.
- retired wraps from 2^CNTW-1 to 0.
- Pointers wrap modulo DEPTH.
- Forwarding:
  - Combinational search over valid queued entries only; the in_* inputs are not searched.
  - If several entries match, the youngest (most recently pushed) wins.
  - A lookup of address 0 never hits.
  - The head entry still hits during the cycle it commits. After the pop edge it no longer hits.
- Ordering:
  - Writes reach RF strictly in acceptance order.
  - Two queued writes to the same register both commit, older first.
- rf_ready held low indefinitely: the queue fills, in_ready stays low, and state holds with no loss.

Decomposition:
- Shared include (alongside the existing hdl include):
  - default RFW/DW constants
  - REG_ZERO = 0
  - a writeback-entry width macro (RFW+DW)
- One sub-module: wb_fifo.
  - Parameterised DEPTH x (RFW+DW) storage with count, pointers, and per-entry valid vector exposed for the forwarding search.
- rf_writeback holds the handshake, the discard/retire logic, and the youngest-match forwarding mux.

Test Plan:
- Reset, then in_valid=1, in_we=1, in_rd=3, in_data=0xDEADBEEF, rf_ready=1 → next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF. Empty after the following edge; retired=1.
- rf_ready=0; push rd=5/0x11, then rd=6/0x22 → pending=2, in_ready=0. A third in_valid is not accepted. Raise rf_ready → commits in order 5 then 6.
- rf_ready=0; push rd=7/0xA, then rd=7/0xB; fwd_addrA=7 → fwd_hitA=1, fwd_dataA=0xB. fwd_addrB=0 → fwd_hitB=0.
- in_rd=0 with in_we=1, and separately in_we=0 → no rf_we pulse; retired increments by 1 for each.
- Queue holds 2 entries with rf_ready=0; assert start for one cycle together with in_valid=1 → pending=0, rf_we=0, retired=0, and no later RF write of the discarded entries.
- Preload retired to 0xFFFF by driving 65535 discarded accepts, then one more → retired=0x0000.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// Shared definitions for the register-file writeback path.
// Default geometry, the hard-wired zero register, and the queue entry width.
// Pure declarations; no logic.
`ifndef RF_WRITEBACK_DEFS_SVH
`define RF_WRITEBACK_DEFS_SVH
// Width of one queued writeback entry: {destination address, result data}.
`define RFWB_ENTRY_W(rfw, dw) ((rfw) + (dw))
`endif

package rf_writeback_pkg;

  localparam int RFW_DEF   = 5;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNTW_DEF  = 16;

  // Register 0 is hard-wired; writes to it are dropped and it never forwards.
  localparam int REG_ZERO  = 0;

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// In-order writeback queue: DEPTH x W storage with count, pointers and per-entry valid bits.
// Latency: a push is visible at the head/outputs the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module wb_fifo
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = `RFWB_ENTRY_W(RFW_DEF, DW_DEF),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                    clk,
  input  logic                    start,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            push_dat,
  output logic [DEPTH-1:0][W-1:0] mem_o,
  output logic [DEPTH-1:0]        vld_o,
  output logic [PW-1:0]           rd_ptr_o,
  output logic [CW-1:0]           count_o
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  // Next-state: push writes at the tail, pop retires the head; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
  end

  // Control state; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (start) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload; qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign mem_o    = mem_q;
  assign vld_o    = vld_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/rf_writeback.sv
// RF write side: queues execute results, drains one per cycle into the RF write port, forwards pending writes.
// Latency: accept at edge N drives rf_we after edge N; commits at the first later edge with rf_ready.
// Backpressure: in_ready drops when the queue is full; rf_ready low holds the head with no loss.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int RFW   = RFW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic [RFW-1:0]  in_rd,
  input  logic [DW-1:0]   in_data,
  output logic            rf_we,
  output logic [RFW-1:0]  rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  input  logic            rf_ready,
  input  logic [RFW-1:0]  fwd_addrA,
  input  logic [RFW-1:0]  fwd_addrB,
  output logic            fwd_hitA,
  output logic            fwd_hitB,
  output logic [DW-1:0]   fwd_dataA,
  output logic [DW-1:0]   fwd_dataB,
  output logic [CW-1:0]   pending,
  output logic [CNTW-1:0] retired
);

  localparam int W = `RFWB_ENTRY_W(RFW, DW);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH-1:0]        vld;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [W-1:0]            head;

  logic accept, do_push, discard, do_pop;
  logic [CNTW-1:0] retired_q, retired_d;

  // Ready depends only on occupancy, so a pop this cycle frees the slot next cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign do_push  = accept && in_we && (in_rd != RFW'(REG_ZERO));
  assign discard  = accept && !do_push;
  assign rf_we    = (count != '0);
  assign do_pop   = rf_we && rf_ready;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk      (clk),
    .start    (start),
    .push     (do_push),
    .pop      (do_pop),
    .push_dat ({in_rd, in_data}),
    .mem_o    (mem),
    .vld_o    (vld),
    .rd_ptr_o (rd_ptr),
    .count_o  (count)
  );

  assign head     = mem[rd_ptr];
  assign rf_waddr = rf_we ? head[W-1:DW] : '0;
  assign rf_wdata = rf_we ? head[DW-1:0] : '0;
  assign pending  = count;

  // Every result retires once: either dropped at accept or committed at pop.
  always_comb begin
    retired_d = retired_q + CNTW'(discard) + CNTW'(do_pop);
  end

  // Retired counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (start) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;

  logic [PW-1:0] idx;
  logic [W-1:0]  ent;

  // Walk entries oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hitA  = 1'b0;
    fwd_hitB  = 1'b0;
    fwd_dataA = '0;
    fwd_dataB = '0;
    idx       = '0;
    ent       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      ent = mem[idx];
      if (vld[idx] && (ent[W-1:DW] == fwd_addrA) && (fwd_addrA != RFW'(REG_ZERO))) begin
        fwd_hitA  = 1'b1;
        fwd_dataA = ent[DW-1:0];
      end
      if (vld[idx] && (ent[W-1:DW] == fwd_addrB) && (fwd_addrB != RFW'(REG_ZERO))) begin
        fwd_hitB  = 1'b1;
        fwd_dataB = ent[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: a queue model predicts drain order, forwarding and counters.
// Inputs change 1ns after posedge; the model samples and checks on negedge.
// Directed scenarios first, then random traffic, reset-discard and counter wrap.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        start;
  logic        in_valid, in_ready, in_we;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_we, rf_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_addrA, fwd_addrB;
  logic        fwd_hitA, fwd_hitB;
  logic [31:0] fwd_dataA, fwd_dataB;
  logic [1:0]  pending;
  logic [15:0] retired;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb_q[$];
  logic [15:0] m_ret = '0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  rf_writeback dut (
    .clk       (clk),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_we     (in_we),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_ready  (rf_ready),
    .fwd_addrA (fwd_addrA),
    .fwd_addrB (fwd_addrB),
    .fwd_hitA  (fwd_hitA),
    .fwd_hitB  (fwd_hitB),
    .fwd_dataA (fwd_dataA),
    .fwd_dataB (fwd_dataB),
    .pending   (pending),
    .retired   (retired)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_valid = v;
    in_we    = we;
    in_rd    = rd;
    in_data  = d;
    rf_ready = rdy;
  endtask

  // Scoreboard: check outputs for the current state, then advance the model across the next edge.
  always @(negedge clk) begin
    logic        hit_a, hit_b, pop, acc, psh;
    logic [31:0] dat_a, dat_b;
    if (armed) begin
      hit_a = 1'b0; hit_b = 1'b0; dat_a = '0; dat_b = '0;
      foreach (sb_q[i]) begin
        if (sb_q[i].a == fwd_addrA && fwd_addrA != 5'd0) begin hit_a = 1'b1; dat_a = sb_q[i].d; end
        if (sb_q[i].a == fwd_addrB && fwd_addrB != 5'd0) begin hit_b = 1'b1; dat_b = sb_q[i].d; end
      end
      chk("in_ready", in_ready, 64'(sb_q.size() < 2));
      chk("rf_we",    rf_we,    64'(sb_q.size() != 0));
      chk("pending",  pending,  64'(sb_q.size()));
      chk("retired",  retired,  64'(m_ret));
      chk("rf_waddr", rf_waddr, sb_q.size() != 0 ? 64'(sb_q[0].a) : 64'd0);
      chk("rf_wdata", rf_wdata, sb_q.size() != 0 ? 64'(sb_q[0].d) : 64'd0);
      chk("fwd_hitA",  fwd_hitA,  64'(hit_a));
      chk("fwd_dataA", fwd_dataA, 64'(dat_a));
      chk("fwd_hitB",  fwd_hitB,  64'(hit_b));
      chk("fwd_dataB", fwd_dataB, 64'(dat_b));
    end
    if (start) begin
      sb_q.delete();
      m_ret = '0;
      armed = 1'b1;
    end else if (armed) begin
      pop = (sb_q.size() != 0) && rf_ready;
      acc = in_valid && (sb_q.size() < 2);
      psh = acc && in_we && (in_rd != 5'd0);
      if (pop) void'(sb_q.pop_front());
      if (psh) sb_q.push_back('{a: in_rd, d: in_data});
      m_ret = m_ret + 16'(pop) + 16'(acc && !psh);
    end
  end

  initial begin
    start = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_rd = '0; in_data = '0;
    rf_ready = 1'b0; fwd_addrA = '0; fwd_addrB = '0;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hitA", fwd_hitA, 0);
    chk("rst_pending", pending, 0);
    chk("rst_retired", retired, 0);

    // Single write, minimum latency.
    drive(1, 1, 5'd3, 32'hDEADBEEF, 1);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t1_pending", pending, 0);
    chk("t1_retired", retired, 1);

    // Fill with RF stalled, third offer refused, then ordered drain.
    drive(1, 1, 5'd5, 32'h11, 0);
    drive(1, 1, 5'd6, 32'h22, 0);
    drive(1, 1, 5'd9, 32'h99, 0);
    @(negedge clk);
    chk("t2_pending", pending, 2);
    chk("t2_in_ready", in_ready, 0);
    drive(1, 1, 5'd9, 32'h99, 0);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t2_first", rf_waddr, 5);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t2_second", rf_waddr, 6);
    chk("t2_second_d", rf_wdata, 32'h22);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t2_empty", pending, 0);

    // Two writes to the same register: youngest forwards, address 0 never hits.
    drive(1, 1, 5'd7, 32'hA, 0);
    drive(1, 1, 5'd7, 32'hB, 0);
    drive(0, 0, 5'd0, 32'h0, 0);
    fwd_addrA = 5'd7;
    fwd_addrB = 5'd0;
    @(negedge clk);
    chk("t3_hitA", fwd_hitA, 1);
    chk("t3_dataA", fwd_dataA, 32'hB);
    chk("t3_hitB", fwd_hitB, 0);
    chk("t3_dataB", fwd_dataB, 0);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t3_commit_hit", fwd_hitA, 1);
    chk("t3_old_first", rf_wdata, 32'hA);
    repeat (2) drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t3_after_pop", fwd_hitA, 0);

    // Discarded results: rd=0 and we=0.
    drive(1, 1, 5'd0, 32'h55, 1);
    drive(1, 0, 5'd4, 32'h66, 1);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t4_no_we", rf_we, 0);
    chk("t4_retired", retired, 7);

    // Random traffic; the scoreboard checks every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) != 0));
      fwd_addrA = 5'($urandom_range(0, 7));
      fwd_addrB = 5'($urandom_range(0, 7));
    end

    // Reset with a full queue and a concurrent offer discards everything.
    drive(1, 1, 5'd8, 32'h1, 0);
    drive(1, 1, 5'd9, 32'h2, 0);
    drive(0, 0, 5'd0, 32'h0, 0);
    @(posedge clk);
    #1;
    start = 1'b1; in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd10; in_data = 32'h3; rf_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
    @(negedge clk);
    chk("t5_pending", pending, 0);
    chk("t5_rf_we", rf_we, 0);
    chk("t5_retired", retired, 0);
    repeat (3) drive(0, 0, 5'd0, 32'h0, 1);

    // Retired counter wrap.
    for (int i = 0; i < 65535; i++) drive(1, 0, 5'd1, 32'h0, 1);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t6_max", retired, 16'hFFFF);
    drive(1, 0, 5'd1, 32'h0, 1);
    drive(0, 0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t6_wrap", retired, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
